// File: rtl/uart_mem_loader.sv
// Framed byte-stream loader: SYNC, TGT, LEN_LO, LEN_HI, N little-endian words, [CKSUM] -> word writes.
// Define LOADER_CKSUM_EN to expect and verify a trailing 8-bit sum of the data bytes.
module uart_mem_loader #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned NumTargets    = 2,
  parameter logic [7:0]  SyncByte      = 8'hA5,
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic [NumTargets-1:0] we_o,
  output logic [AddrWidth-1:0]  addr_o,
  output logic [DataWidth-1:0]  wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [2:0]            err_code_o,
  output logic                  core_rst_o
);

  localparam int unsigned Bytes   = DataWidth / 8;
  localparam int unsigned BcW     = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam int unsigned TgtW    = (NumTargets > 1) ? $clog2(NumTargets) : 1;
  localparam int unsigned TmoW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [31:0] MaxWords = (AddrWidth < 16) ? (32'd1 << AddrWidth) : 32'h0001_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_TGT, S_LEN0, S_LEN1, S_DATA, S_CKSUM, S_DONE, S_ERR
  } state_e;

`ifdef LOADER_CKSUM_EN
  localparam state_e PostData = S_CKSUM;
`else
  localparam state_e PostData = S_DONE;
`endif

  state_e                state_q, state_d;
  logic [TgtW-1:0]       tgt_q, tgt_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           rem_q, rem_d;
  logic [AddrWidth-1:0]  waddr_q, waddr_d;
  logic [BcW-1:0]        bcnt_q, bcnt_d;
  logic [DataWidth-1:0]  pack_q, pack_d;
  logic [7:0]            sum_q, sum_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [NumTargets-1:0] we_q, we_d, we_sel;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [2:0]            code_q, code_d;
  logic                  core_rst_q, core_rst_d;
  logic                  byte_take, active, tmo_hit;
  logic [15:0]           len_full;

  assign byte_take = rx_dv_i && (state_q == S_DATA);
  assign len_full  = {rx_byte_i, len_lo_q};

  // Each incoming data byte lands directly in its lane, so the completed word is pack_d.
  for (genvar gi = 0; gi < Bytes; gi++) begin : g_lane
    assign pack_d[gi*8 +: 8] = (byte_take && (bcnt_q == BcW'(gi))) ? rx_byte_i : pack_q[gi*8 +: 8];
  end

  for (genvar gi = 0; gi < NumTargets; gi++) begin : g_we_sel
    assign we_sel[gi] = (tgt_q == TgtW'(gi));
  end

  assign active  = (state_q == S_TGT) || (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA) || (state_q == S_CKSUM);
  // A byte in the expiry cycle suppresses the timeout because tmo_hit requires !rx_dv_i.
  assign tmo_hit = (TimeoutCycles != 0) && active && !rx_dv_i && (tmo_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    len_lo_d   = len_lo_q;
    rem_d      = rem_q;
    waddr_d    = waddr_q;
    bcnt_d     = bcnt_q;
    sum_d      = sum_q;
    we_d       = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    code_d     = code_q;
    core_rst_d = core_rst_q;
    tmo_d      = (rx_dv_i || !active) ? '0 : tmo_q + 1'b1;

    case (state_q)
      S_IDLE: if (rx_dv_i && (rx_byte_i == SyncByte)) begin
        state_d = S_TGT;
        err_d   = 1'b0;
        code_d  = 3'd0;
        sum_d   = 8'd0;
        bcnt_d  = '0;
        waddr_d = '0;
      end
      S_TGT: if (rx_dv_i) begin
        if ({24'd0, rx_byte_i} >= NumTargets) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = 3'd1;
        end else begin
          tgt_d      = TgtW'(rx_byte_i);
          core_rst_d = 1'b1;
          state_d    = S_LEN0;
        end
      end
      S_LEN0: if (rx_dv_i) begin
        len_lo_d = rx_byte_i;
        state_d  = S_LEN1;
      end
      S_LEN1: if (rx_dv_i) begin
        if ({16'd0, len_full} > MaxWords) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = 3'd2;
        end else if (len_full == 16'd0) begin
          state_d = PostData;
        end else begin
          rem_d   = len_full;
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_dv_i) begin
        sum_d = sum_q + rx_byte_i;
        if (bcnt_q == BcW'(Bytes - 1)) begin
          bcnt_d  = '0;
          we_d    = we_sel;
          addr_d  = waddr_q;
          wdata_d = pack_d;
          waddr_d = waddr_q + 1'b1;
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = PostData;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      S_CKSUM: if (rx_dv_i) begin
        if (rx_byte_i == sum_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = 3'd3;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo_hit) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      code_d  = 3'd4;
    end
    if ((state_d == S_DONE) || (state_d == S_ERR)) core_rst_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      len_lo_q   <= '0;
      rem_q      <= '0;
      waddr_q    <= '0;
      bcnt_q     <= '0;
      pack_q     <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      code_q     <= 3'd0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      len_lo_q   <= len_lo_d;
      rem_q      <= rem_d;
      waddr_q    <= waddr_d;
      bcnt_q     <= bcnt_d;
      pack_q     <= pack_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      code_q     <= code_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign we_o       = we_q;
  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign err_o      = err_q;
  assign err_code_o = code_q;
  assign core_rst_o = core_rst_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Randomized scoreboard bench for uart_mem_loader; expected events come from a frame-level model.
module tb_uart_mem_loader;

  localparam int TMO = 200;
  localparam int NT  = 2;
`ifdef LOADER_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rx_dv_i;
  logic [7:0]  rx_byte_i;
  logic [1:0]  we_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic        busy_o, done_o, err_o, core_rst_o;
  logic [2:0]  err_code_o;

  uart_mem_loader #(
    .DataWidth(32), .AddrWidth(12), .NumTargets(NT), .SyncByte(8'hA5), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i),
    .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .err_code_o(err_code_o), .core_rst_o(core_rst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          kind;
    logic [7:0]  we;
    logic [15:0] addr;
    logic [31:0] data;
    logic [2:0]  code;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] data_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte_i = b;
    rx_dv_i   = 1'b1;
    tick();
    rx_dv_i   = 1'b0;
  endtask

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a write, done pulse or new error.
  initial begin
    ev_t  e;
    logic err_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        if (we_o != 2'b00) begin
          if (exp_q.size() == 0) check("unexpected_we", 64'(we_o), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("wr_kind", 64'(e.kind), 64'(K_WR));
            check("we_o", 64'(we_o), 64'(e.we));
            check("addr_o", 64'(addr_o), 64'(e.addr));
            check("wdata_o", 64'(wdata_o), 64'(e.data));
          end
        end
        if (done_o) begin
          if (exp_q.size() == 0) check("unexpected_done", 64'(done_o), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("done_kind", 64'(e.kind), 64'(K_DONE));
            check("err_o_at_done", 64'(err_o), 64'd0);
          end
        end
        if (err_o && !err_prev) begin
          if (exp_q.size() == 0) check("unexpected_err", 64'(err_o), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("err_kind", 64'(e.kind), 64'(K_ERR));
            check("err_code_o", 64'(err_code_o), 64'(e.code));
          end
        end
      end
      err_prev = err_o;
    end
  end

  // Model works on whole frames: it decides where the frame stops and what it must produce.
  task automatic run_frame(input int tgt, input int len, input int cks_ovr,
                           input int stall_idx, input int stall_gap);
    logic [7:0] fr[$];
    logic [7:0] sum;
    logic [7:0] cks;
    int         full, end_n, nwr, code;
    ev_t        e;
    sum = 8'd0;
    foreach (data_q[i]) sum = sum + data_q[i];
    cks = (cks_ovr == -1) ? sum : (cks_ovr == -2) ? sum + 8'd1 : 8'(cks_ovr);
    fr.push_back(8'hA5);
    fr.push_back(8'(tgt));
    fr.push_back(8'(len));
    fr.push_back(8'(len >> 8));
    foreach (data_q[i]) fr.push_back(data_q[i]);
    if (CK == 1) fr.push_back(cks);

    full = 4 + 4 * len + CK;
    if (tgt >= NT) begin
      end_n = 2; nwr = 0; code = 1;
    end else if (len > 4096) begin
      end_n = 4; nwr = 0; code = 2;
    end else if (stall_idx >= 0 && stall_idx < full - 1 && stall_gap >= TMO) begin
      end_n = stall_idx + 1; nwr = (end_n > 4) ? (end_n - 4) / 4 : 0; code = 4;
    end else begin
      end_n = full; nwr = len; code = (CK == 1 && cks != sum) ? 3 : 0;
    end

    for (int w = 0; w < nwr; w++) begin
      e.kind = K_WR;
      e.we   = 8'(1 << tgt);
      e.addr = 16'(w);
      e.data = {data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]};
      e.code = 3'd0;
      exp_q.push_back(e);
    end
    e.kind = (code == 0) ? K_DONE : K_ERR;
    e.we = 8'd0; e.addr = 16'd0; e.data = 32'd0; e.code = 3'(code);
    exp_q.push_back(e);

    for (int i = 0; i < end_n; i++) begin
      send_byte(fr[i]);
      if (i == 1 && tgt < NT && end_n > 2) begin
        check("core_rst_in_frame", 64'(core_rst_o), 64'd1);
        check("busy_in_frame", 64'(busy_o), 64'd1);
      end
      if (i == stall_idx) repeat (stall_gap) tick();
      else if (i < end_n - 1) repeat ($urandom_range(0, 2)) tick();
    end
    repeat (4) tick();
    check("pending_events", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("busy_after_frame", 64'(busy_o), 64'd0);
    check("core_rst_after_frame", 64'(core_rst_o), 64'd0);
    $display("frame tgt=%0d len=%0d end=%0d code=%0d", tgt, len, end_n, code);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 64'(we_o), 64'd0);
    check({tag, "_addr"}, 64'(addr_o), 64'd0);
    check({tag, "_wdata"}, 64'(wdata_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_done"}, 64'(done_o), 64'd0);
    check({tag, "_err"}, 64'(err_o), 64'd0);
    check({tag, "_code"}, 64'(err_code_o), 64'd0);
    check({tag, "_core_rst"}, 64'(core_rst_o), 64'd0);
  endtask

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, tgt;
    rst_ni = 1'b0; rx_dv_i = 1'b0; rx_byte_i = 8'h00;
    repeat (3) tick();
    check_all_zero("reset");
    rst_ni = 1'b1;
    tick();

    data_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_frame(0, 2, 8'h24, -1, 0);

    data_q.delete();
    run_frame(5, 0, -1, -1, 0);

    data_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(1, 1, 8'h00, -1, 0);

    data_q = {8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(0, 1, -1, 2, TMO);
    check("timeout_code", 64'(err_code_o), 64'd4);
    run_frame(0, 1, -1, 2, TMO - 1);

    data_q.delete();
    run_frame(0, 16'h1001, -1, -1, 0);
    run_frame(1, 0, -1, -1, 0);

    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    check("busy_before_reset", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    tick();
    check_all_zero("midframe_reset");
    rst_ni = 1'b1;
    tick();
    data_q.delete();
    for (int i = 0; i < 8; i++) data_q.push_back(rand_byte());
    run_frame(1, 2, -1, -1, 0);

    for (int f = 0; f < 40; f++) begin
      tgt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 255)) : int'($urandom_range(0, 1));
      len = $urandom_range(0, 4);
      data_q.delete();
      for (int i = 0; i < 4 * len; i++) data_q.push_back(rand_byte());
      run_frame(tgt, len, ($urandom_range(0, 3) == 0) ? -2 : -1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
